regfile_sequencer: RTL and testbench

- Initiator side of the 4x10-bit register file interface: accepts 10-bit instruction words over a valid/ready handshake and drives the register file's write and read ports.
- Performs one register-to-register operation per instruction (read Rx/Ry, execute, write back) or a load-immediate.
- Sits between instruction fetch and the register file.
- Has a multi-cycle FSM, operand/result registers and status flags.

---
 rtl/regfile_pkg.sv | 38 +++
 rtl/regfile_seq_alu.sv | 43 ++++
 rtl/regfile_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and enumerations for the register-file sequencer.
// Holds the word/address widths, opcode and FSM state encodings, and the IR field positions.
package regfile_pkg;

  localparam int RF_WIDTH = 10;
  localparam int RF_AW    = 2;

  // Only the low byte of an instruction is decoded; bits [9:8] are reserved.
  localparam int IR_W   = 8;
  localparam int OP_LSB = 0;
  localparam int OP_MSB = 3;
  localparam int RX_LSB = 4;
  localparam int RX_MSB = 5;
  localparam int RY_LSB = 6;
  localparam int RY_MSB = 7;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_MOV  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_OUT  = 4'd8
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IMM  = 3'd1,
    ST_READ = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_OUTP = 3'd5
  } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational ALU for the sequencer: opcode plus operands A and B give the result and carry.
// Carry is the carry-out for ADD and the unsigned borrow for SUB; every other opcode returns zero.
module regfile_seq_alu
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_s = {1'b0, a_i} - {1'b0, b_i};

  // Operation select; the extra MSB of diff_s is set exactly when a_i < b_i.
  always_comb begin
    result_o = {WIDTH{1'b0}};
    carry_o  = 1'b0;
    case (op_i)
      OP_MOV: result_o = b_i;
      OP_ADD: begin
        result_o = sum_s[WIDTH-1:0];
        carry_o  = sum_s[WIDTH];
      end
      OP_SUB: begin
        result_o = diff_s[WIDTH-1:0];
        carry_o  = diff_s[WIDTH];
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOT:  result_o = ~b_i;
      default: result_o = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Instruction sequencer driving a 4-entry register file: decodes one word, reads Rx/Ry,
// executes, writes back, or emits Rx on RESULT. All outputs decode from registered state.
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int AW    = RF_AW
) (
  input  logic             CLKb,
  input  logic             RSTb,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] RF_D,
  output logic             RF_ENW,
  output logic [AW-1:0]    RF_WRA,
  output logic             RF_ENR0,
  output logic             RF_ENR1,
  output logic [AW-1:0]    RF_RDA0,
  output logic [AW-1:0]    RF_RDA1,
  input  logic [WIDTH-1:0] RF_Q0,
  input  logic [WIDTH-1:0] RF_Q1,
  output logic [WIDTH-1:0] RESULT,
  output logic             RES_VALID,
  output logic             DONE,
  output logic             ILLEGAL,
  output logic             FLAG_Z,
  output logic             FLAG_C
);

  state_e            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;

  logic [3:0]        op_s;
  logic [AW-1:0]     rx_s;
  logic [AW-1:0]     ry_s;
  logic              illegal_s;
  logic [WIDTH-1:0]  alu_res_s;
  logic              alu_carry_s;

  assign op_s      = ir_q[OP_MSB:OP_LSB];
  assign rx_s      = ir_q[RX_MSB:RX_LSB];
  assign ry_s      = ir_q[RY_MSB:RY_LSB];
  assign illegal_s = (op_s > 4'd8);

  regfile_seq_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op_i     (op_s),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_res_s),
    .carry_o  (alu_carry_s)
  );

  // State, operand, result and flag registers; reset abandons any in-flight instruction.
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state_q  <= ST_IDLE;
      ir_q     <= {IR_W{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          ir_d = DIN[IR_W-1:0];
          if (DIN[OP_MSB:OP_LSB] == OP_LOAD) begin
            state_d = ST_IMM;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IMM: begin
        if (IN_VALID) begin
          res_d   = DIN;
          state_d = ST_WB;
        end else begin
          state_d = ST_IMM;
        end
      end
      ST_READ: begin
        a_d = RF_Q0;
        b_d = RF_Q1;
        if (illegal_s) begin
          state_d = ST_IDLE;
        end else if (op_s == OP_OUT) begin
          state_d = ST_OUTP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_res_s;
        state_d = ST_WB;
        // MOV is the only opcode reaching EXEC that must leave the flags alone.
        if (op_s != OP_MOV) begin
          flag_z_d = (alu_res_s == {WIDTH{1'b0}});
          flag_c_d = alu_carry_s;
        end else begin
          flag_z_d = flag_z_q;
          flag_c_d = flag_c_q;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      ST_OUTP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; every data/address output is zero unless its enable is high.
  always_comb begin
    IN_READY  = 1'b0;
    RF_D      = {WIDTH{1'b0}};
    RF_ENW    = 1'b0;
    RF_WRA    = {AW{1'b0}};
    RF_ENR0   = 1'b0;
    RF_ENR1   = 1'b0;
    RF_RDA0   = {AW{1'b0}};
    RF_RDA1   = {AW{1'b0}};
    RESULT    = {WIDTH{1'b0}};
    RES_VALID = 1'b0;
    DONE      = 1'b0;
    ILLEGAL   = 1'b0;
    FLAG_Z    = flag_z_q;
    FLAG_C    = flag_c_q;
    case (state_q)
      ST_IDLE: IN_READY = 1'b1;
      ST_IMM:  IN_READY = 1'b1;
      ST_READ: begin
        RF_ENR0 = 1'b1;
        RF_ENR1 = 1'b1;
        RF_RDA0 = rx_s;
        RF_RDA1 = ry_s;
        ILLEGAL = illegal_s;
      end
      ST_EXEC: IN_READY = 1'b0;
      ST_WB: begin
        RF_ENW = 1'b1;
        RF_WRA = rx_s;
        RF_D   = res_q;
        DONE   = 1'b1;
      end
      ST_OUTP: begin
        RESULT    = a_q;
        RES_VALID = 1'b1;
        DONE      = 1'b1;
      end
      default: IN_READY = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed self-checking bench for regfile_sequencer with a behavioural 4x10 register file model.
module tb_regfile_sequencer;

  logic       CLKb = 1'b0;
  logic       RSTb = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [9:0] DIN = 10'h000;
  logic [9:0] RF_D;
  logic       RF_ENW;
  logic [1:0] RF_WRA;
  logic       RF_ENR0;
  logic       RF_ENR1;
  logic [1:0] RF_RDA0;
  logic [1:0] RF_RDA1;
  logic [9:0] RF_Q0;
  logic [9:0] RF_Q1;
  logic [9:0] RESULT;
  logic       RES_VALID;
  logic       DONE;
  logic       ILLEGAL;
  logic       FLAG_Z;
  logic       FLAG_C;

  logic [9:0] rf [4];
  int         wr_cnt = 0;
  int         checks = 0;
  int         passed = 0;
  logic [33:0] outs_s;

  regfile_sequencer dut (
    .CLKb      (CLKb),
    .RSTb      (RSTb),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .DIN       (DIN),
    .RF_D      (RF_D),
    .RF_ENW    (RF_ENW),
    .RF_WRA    (RF_WRA),
    .RF_ENR0   (RF_ENR0),
    .RF_ENR1   (RF_ENR1),
    .RF_RDA0   (RF_RDA0),
    .RF_RDA1   (RF_RDA1),
    .RF_Q0     (RF_Q0),
    .RF_Q1     (RF_Q1),
    .RESULT    (RESULT),
    .RES_VALID (RES_VALID),
    .DONE      (DONE),
    .ILLEGAL   (ILLEGAL),
    .FLAG_Z    (FLAG_Z),
    .FLAG_C    (FLAG_C)
  );

  always #5 CLKb = ~CLKb;

  assign RF_Q0  = rf[RF_RDA0];
  assign RF_Q1  = rf[RF_RDA1];
  assign outs_s = {RF_ENW, RF_ENR0, RF_ENR1, RES_VALID, DONE, ILLEGAL, FLAG_Z, FLAG_C,
                   RF_D, RESULT, RF_WRA, RF_RDA0, RF_RDA1};

  always @(posedge CLKb) begin
    if (RF_ENW) begin
      rf[RF_WRA] <= RF_D;
      wr_cnt     <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge CLKb);
    #1;
  endtask

  // Present a word and hold it until the edge that accepts it; return 1 ns after that edge.
  task automatic send_word(input logic [9:0] w);
    int n;
    IN_VALID = 1'b1;
    DIN      = w;
    n        = 0;
    while (!IN_READY && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (IN_READY !== 1'b1) $display("FAIL accept_timeout word=%h IN_READY=%b required 1", w, IN_READY);
    else passed++;
    tick();
    IN_VALID = 1'b0;
    DIN      = 10'h000;
  endtask

  task automatic load_reg(input logic [1:0] rx, input logic [9:0] imm);
    send_word({4'h0, rx, 4'h0});
    send_word(imm);
    tick();
  endtask

  task automatic test_reset();
    #2 RSTb = 1'b0;
    #1;
    checks++;
    if (outs_s !== 34'h0) $display("FAIL reset_outs: got %h required 0", outs_s);
    else passed++;
    tick();
    tick();
    RSTb = 1'b1;
    #1;
    checks++;
    if (IN_READY !== 1'b1) $display("FAIL reset_ready: got %b required 1", IN_READY);
    else passed++;
    checks++;
    if (outs_s !== 34'h0) $display("FAIL reset_outs_released: got %h required 0", outs_s);
    else passed++;
  endtask

  task automatic test_load();
    send_word(10'h010);
    tick();
    tick();
    checks++;
    if (IN_READY !== 1'b1 || RF_ENW !== 1'b0) $display("FAIL imm_hold: IN_READY=%b RF_ENW=%b required 1/0", IN_READY, RF_ENW);
    else passed++;
    send_word(10'h155);
    checks++;
    if ({RF_ENW, RF_WRA, RF_D, DONE} !== {1'b1, 2'd1, 10'h155, 1'b1})
      $display("FAIL load_wb: ENW=%b WRA=%0d D=%h DONE=%b required 1/1/155/1", RF_ENW, RF_WRA, RF_D, DONE);
    else passed++;
    checks++;
    if ({FLAG_Z, FLAG_C} !== 2'b00) $display("FAIL load_flags: got %b required 00", {FLAG_Z, FLAG_C});
    else passed++;
    tick();
    checks++;
    if (rf[1] !== 10'h155 || DONE !== 1'b0) $display("FAIL load_write: R1=%h DONE=%b required 155/0", rf[1], DONE);
    else passed++;
  endtask

  task automatic test_add();
    int cnt0;
    load_reg(2'd0, 10'h3FF);
    load_reg(2'd1, 10'h001);
    cnt0 = wr_cnt;
    send_word(10'h042);
    checks++;
    if ({RF_ENR0, RF_ENR1, RF_RDA0, RF_RDA1, IN_READY} !== {1'b1, 1'b1, 2'd0, 2'd1, 1'b0})
      $display("FAIL add_read: ENR=%b%b RDA0=%0d RDA1=%0d RDY=%b required 11/0/1/0", RF_ENR0, RF_ENR1, RF_RDA0, RF_RDA1, IN_READY);
    else passed++;
    tick();
    checks++;
    if (RF_ENW !== 1'b0) $display("FAIL add_exec_enw: got %b required 0", RF_ENW);
    else passed++;
    tick();
    checks++;
    if ({RF_ENW, RF_WRA, RF_D, DONE} !== {1'b1, 2'd0, 10'h000, 1'b1})
      $display("FAIL add_wb: ENW=%b WRA=%0d D=%h DONE=%b required 1/0/000/1", RF_ENW, RF_WRA, RF_D, DONE);
    else passed++;
    checks++;
    if ({FLAG_Z, FLAG_C} !== 2'b11) $display("FAIL add_flags: ZC=%b required 11", {FLAG_Z, FLAG_C});
    else passed++;
    tick();
    checks++;
    if (rf[0] !== 10'h000 || wr_cnt !== cnt0 + 1) $display("FAIL add_write: R0=%h writes=%0d required 000/%0d", rf[0], wr_cnt, cnt0 + 1);
    else passed++;
  endtask

  task automatic test_sub_out();
    load_reg(2'd2, 10'h005);
    load_reg(2'd3, 10'h007);
    send_word(10'h0E3);
    tick();
    tick();
    checks++;
    if ({RF_ENW, RF_WRA, RF_D} !== {1'b1, 2'd2, 10'h3FE}) $display("FAIL sub_wb: ENW=%b WRA=%0d D=%h required 1/2/3fe", RF_ENW, RF_WRA, RF_D);
    else passed++;
    checks++;
    if ({FLAG_Z, FLAG_C} !== 2'b01) $display("FAIL sub_flags: ZC=%b required 01", {FLAG_Z, FLAG_C});
    else passed++;
    tick();
    send_word(10'h028);
    checks++;
    if (RES_VALID !== 1'b0) $display("FAIL out_early: RES_VALID=%b required 0", RES_VALID);
    else passed++;
    tick();
    checks++;
    if ({RES_VALID, DONE, RESULT, RF_ENW} !== {1'b1, 1'b1, 10'h3FE, 1'b0})
      $display("FAIL out_result: VALID=%b DONE=%b RESULT=%h ENW=%b required 1/1/3fe/0", RES_VALID, DONE, RESULT, RF_ENW);
    else passed++;
    checks++;
    if ({FLAG_Z, FLAG_C} !== 2'b01) $display("FAIL out_flags: ZC=%b required 01", {FLAG_Z, FLAG_C});
    else passed++;
    tick();
    checks++;
    if (RES_VALID !== 1'b0 || RESULT !== 10'h000) $display("FAIL out_pulse: VALID=%b RESULT=%h required 0/000", RES_VALID, RESULT);
    else passed++;
  endtask

  task automatic test_illegal();
    int cnt0;
    cnt0 = wr_cnt;
    send_word(10'h00A);
    checks++;
    if (ILLEGAL !== 1'b1 || RF_ENW !== 1'b0) $display("FAIL illegal_pulse: ILLEGAL=%b ENW=%b required 1/0", ILLEGAL, RF_ENW);
    else passed++;
    tick();
    checks++;
    if ({ILLEGAL, IN_READY, FLAG_Z, FLAG_C} !== 4'b0101) $display("FAIL illegal_after: ILL/RDY/Z/C=%b required 0101", {ILLEGAL, IN_READY, FLAG_Z, FLAG_C});
    else passed++;
    checks++;
    if (wr_cnt !== cnt0) $display("FAIL illegal_nowrite: writes=%0d required %0d", wr_cnt, cnt0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] bw [3];
    logic [9:0] w;
    logic       rdy;
    int         idx;
    bw[0] = 10'h0D2;
    bw[1] = 10'h062;
    bw[2] = 10'h032;
    idx = 0;
    IN_VALID = 1'b1;
    DIN = bw[0];
    for (int i = 0; i < 12; i++) begin
      rdy = IN_READY;
      checks++;
      if (rdy !== (i % 4 == 0)) $display("FAIL b2b_ready cycle %0d: got %b required %b", i, rdy, (i % 4 == 0));
      else passed++;
      checks++;
      if (RF_ENW !== (i % 4 == 3)) $display("FAIL b2b_enw cycle %0d: got %b required %b", i, RF_ENW, (i % 4 == 3));
      else passed++;
      if (i % 4 == 1) begin
        w = bw[i / 4];
        checks++;
        if (RF_RDA0 !== w[5:4] || RF_RDA1 !== w[7:6])
          $display("FAIL b2b_rda cycle %0d: RDA0=%0d RDA1=%0d required %0d/%0d", i, RF_RDA0, RF_RDA1, w[5:4], w[7:6]);
        else passed++;
      end
      tick();
      if (rdy) begin
        idx++;
        if (idx < 3) begin
          DIN = bw[idx];
        end else begin
          IN_VALID = 1'b0;
          DIN = 10'h000;
        end
      end
    end
    checks++;
    if ({rf[1], rf[2], rf[3]} !== {10'h008, 10'h006, 10'h007})
      $display("FAIL b2b_regs: R1=%h R2=%h R3=%h required 008/006/007", rf[1], rf[2], rf[3]);
    else passed++;
    checks++;
    if ({FLAG_Z, FLAG_C} !== 2'b00) $display("FAIL b2b_flags: ZC=%b required 00", {FLAG_Z, FLAG_C});
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cnt0;
    cnt0 = wr_cnt;
    send_word(10'h042);
    tick();
    RSTb = 1'b0;
    #1;
    checks++;
    if (outs_s !== 34'h0) $display("FAIL midrst_outs: got %h required 0", outs_s);
    else passed++;
    tick();
    tick();
    RSTb = 1'b1;
    #1;
    checks++;
    if (wr_cnt !== cnt0 || rf[0] !== 10'h000) $display("FAIL midrst_nowrite: writes=%0d R0=%h required %0d/000", wr_cnt, rf[0], cnt0);
    else passed++;
    checks++;
    if (IN_READY !== 1'b1) $display("FAIL midrst_ready: got %b required 1", IN_READY);
    else passed++;
    load_reg(2'd0, 10'h2AA);
    checks++;
    if (rf[0] !== 10'h2AA) $display("FAIL midrst_load: R0=%h required 2aa", rf[0]);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_add();
    test_sub_out();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
